// File: rtl/bip_exec_monitor.sv
// rtl/bip_exec_monitor.sv - multi-channel execution monitor for the BIP CPU
// Counts run cycles, retired instructions and per-opcode hits; freezes on HLT.
module bip_exec_monitor #(
  parameter int NB_OPCODE  = 5,
  parameter int NB_COUNTER = 16,
  parameter int N_CHANNELS = 4,
  parameter int NB_SEL     = 4,
  parameter logic [NB_OPCODE-1:0] HALT_OPCODE = 5'b00000,
  parameter logic [(N_CHANNELS-2)*NB_OPCODE-1:0] CH_OPCODES = {5'b00010, 5'b00001},
  parameter bit SATURATE   = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic                  i_clear,
  input  logic                  i_valid,
  input  logic [NB_OPCODE-1:0]  i_opcode,
  input  logic                  i_rd_req,
  input  logic [NB_SEL-1:0]     i_rd_sel,
  output logic                  o_rd_valid,
  output logic [NB_COUNTER-1:0] o_rd_data,
  output logic                  o_rd_err,
  output logic                  o_running,
  output logic                  o_halted,
  output logic [N_CHANNELS-1:0] o_overflow
);

  if (N_CHANNELS < 3 || N_CHANNELS > 16 || NB_SEL < $clog2(N_CHANNELS)) begin : g_bad_params
    $error("bip_exec_monitor: N_CHANNELS must be 3..16 and NB_SEL >= clog2(N_CHANNELS)");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam logic [NB_COUNTER-1:0] ONE      = NB_COUNTER'(1);
  localparam logic [NB_COUNTER-1:0] ALL_ONES = '1;

  state_t                state_q;
  state_t                state_d;
  logic [NB_COUNTER-1:0] cnt [N_CHANNELS];
  logic [N_CHANNELS-1:0] inc;
  logic                  rd_in_range;
  logic [NB_COUNTER-1:0] rd_mux;

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Clear overrides every other transition, including the halting one.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_start) state_d = RUN;
      RUN:     if (i_valid && i_opcode == HALT_OPCODE) state_d = HALTED;
      HALTED:  state_d = HALTED;
      default: state_d = IDLE;
    endcase
    if (i_clear) state_d = IDLE;
  end

  assign o_running = (state_q == RUN);
  assign o_halted  = (state_q == HALTED);

  always_comb begin
    inc    = '0;
    inc[0] = 1'b1;
    inc[1] = i_valid;
    for (int k = 2; k < N_CHANNELS; k++) begin
      inc[k] = i_valid && (i_opcode == CH_OPCODES[(k-2)*NB_OPCODE +: NB_OPCODE]);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      for (int k = 0; k < N_CHANNELS; k++) cnt[k] <= '0;
      o_overflow <= '0;
    end else if (state_q == RUN) begin
      for (int k = 0; k < N_CHANNELS; k++) begin
        if (inc[k]) begin
          if (cnt[k] == ALL_ONES) begin
            o_overflow[k] <= 1'b1;
            cnt[k]        <= SATURATE ? ALL_ONES : '0;
          end else begin
            cnt[k] <= cnt[k] + ONE;
          end
        end
      end
    end
  end

  // Select is zero-extended so any out-of-range code returns zero with an error flag.
  always_comb begin
    rd_in_range = (32'(i_rd_sel) < N_CHANNELS);
    rd_mux      = '0;
    for (int k = 0; k < N_CHANNELS; k++) begin
      if (32'(i_rd_sel) == k) rd_mux = cnt[k];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_rd_valid <= 1'b0;
      o_rd_data  <= '0;
      o_rd_err   <= 1'b0;
    end else begin
      o_rd_valid <= i_rd_req;
      o_rd_data  <= (i_rd_req && rd_in_range) ? rd_mux : '0;
      o_rd_err   <= i_rd_req && !rd_in_range;
    end
  end

endmodule

// File: tb/tb_bip_exec_monitor.sv
// tb/tb_bip_exec_monitor.sv - directed self-checking bench for bip_exec_monitor
// Shared stimulus drives a default instance plus 4-bit saturating and wrapping instances.
module tb_bip_exec_monitor;

  localparam logic [4:0] OP_HLT = 5'b00000;
  localparam logic [4:0] OP_LD  = 5'b00001;
  localparam logic [4:0] OP_STO = 5'b00010;
  localparam logic [4:0] OP_ADD = 5'b00100;

  logic        clk = 1'b0;
  logic        rst, start, clear, valid, rd_req;
  logic [4:0]  opcode;
  logic [3:0]  rd_sel;

  logic        rd_valid, rd_err, running, halted;
  logic [15:0] rd_data;
  logic [3:0]  overflow;

  logic        sat_rd_valid, sat_rd_err, sat_running, sat_halted;
  logic [3:0]  sat_rd_data, sat_overflow;
  logic        wrap_rd_valid, wrap_rd_err, wrap_running, wrap_halted;
  logic [3:0]  wrap_rd_data, wrap_overflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bip_exec_monitor dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_clear(clear),
    .i_valid(valid), .i_opcode(opcode), .i_rd_req(rd_req), .i_rd_sel(rd_sel),
    .o_rd_valid(rd_valid), .o_rd_data(rd_data), .o_rd_err(rd_err),
    .o_running(running), .o_halted(halted), .o_overflow(overflow)
  );

  bip_exec_monitor #(.NB_COUNTER(4), .SATURATE(1'b1)) dut_sat (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_clear(clear),
    .i_valid(valid), .i_opcode(opcode), .i_rd_req(rd_req), .i_rd_sel(rd_sel),
    .o_rd_valid(sat_rd_valid), .o_rd_data(sat_rd_data), .o_rd_err(sat_rd_err),
    .o_running(sat_running), .o_halted(sat_halted), .o_overflow(sat_overflow)
  );

  bip_exec_monitor #(.NB_COUNTER(4), .SATURATE(1'b0)) dut_wrap (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_clear(clear),
    .i_valid(valid), .i_opcode(opcode), .i_rd_req(rd_req), .i_rd_sel(rd_sel),
    .o_rd_valid(wrap_rd_valid), .o_rd_data(wrap_rd_data), .o_rd_err(wrap_rd_err),
    .o_running(wrap_running), .o_halted(wrap_halted), .o_overflow(wrap_overflow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // One rising edge; outputs are sampled 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic retire(input logic v, input logic [4:0] op);
    valid  = v;
    opcode = op;
    step();
    valid  = 1'b0;
    opcode = OP_ADD;
  endtask

  task automatic rd_check(input string tag, input logic [3:0] sel, input logic [15:0] exp);
    rd_req = 1'b1;
    rd_sel = sel;
    step();
    rd_req = 1'b0;
    check({tag, "_valid"}, 32'(rd_valid), 32'd1);
    check({tag, "_data"}, 32'(rd_data), 32'(exp));
    check({tag, "_err"}, 32'(rd_err), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; clear = 1'b0; valid = 1'b0;
    opcode = OP_ADD; rd_req = 1'b0; rd_sel = '0;
    #2;
    step();
    rst = 1'b0;
    check("rst_running", 32'(running), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    rd_check("rst_ch0", 4'd0, 16'd0);

    // Basic run: LD, STO, idle, ADD, idle, LD, HLT -> 7 RUN cycles.
    start = 1'b1; step(); start = 1'b0;
    check("start_running", 32'(running), 32'd1);
    retire(1'b1, OP_LD);
    retire(1'b1, OP_STO);
    retire(1'b0, OP_HLT);
    retire(1'b1, OP_ADD);
    retire(1'b0, OP_HLT);
    retire(1'b1, OP_LD);
    check("pre_hlt_running", 32'(running), 32'd1);
    retire(1'b1, OP_HLT);
    check("hlt_halted", 32'(halted), 32'd1);
    check("hlt_running", 32'(running), 32'd0);
    rd_check("run_ch0", 4'd0, 16'd7);
    rd_check("run_ch1", 4'd1, 16'd5);
    rd_check("run_ch2", 4'd2, 16'd2);
    rd_check("run_ch3", 4'd3, 16'd1);
    steps(10);
    rd_check("hold_ch0", 4'd0, 16'd7);
    rd_check("hold_ch1", 4'd1, 16'd5);

    // Back-to-back reads including an out-of-range select.
    rd_req = 1'b1; rd_sel = 4'd0; step();
    check("b2b0_valid", 32'(rd_valid), 32'd1);
    check("b2b0_data", 32'(rd_data), 32'd7);
    rd_sel = 4'd1; step();
    check("b2b1_valid", 32'(rd_valid), 32'd1);
    check("b2b1_data", 32'(rd_data), 32'd5);
    rd_sel = 4'd4; step();
    rd_req = 1'b0;
    check("b2b2_valid", 32'(rd_valid), 32'd1);
    check("b2b2_data", 32'(rd_data), 32'd0);
    check("b2b2_err", 32'(rd_err), 32'd1);
    step();
    check("idle_rd_valid", 32'(rd_valid), 32'd0);
    check("idle_rd_err", 32'(rd_err), 32'd0);
    check("idle_rd_data", 32'(rd_data), 32'd0);

    // Start ignored while halted.
    start = 1'b1; step(); start = 1'b0;
    check("start_halted_state", 32'(halted), 32'd1);
    rd_check("start_halted_ch0", 4'd0, 16'd7);

    // Clear beats start.
    clear = 1'b1; start = 1'b1; step(); clear = 1'b0; start = 1'b0;
    check("clr_running", 32'(running), 32'd0);
    check("clr_halted", 32'(halted), 32'd0);
    check("clr_overflow", 32'(overflow), 32'd0);
    rd_check("clr_ch0", 4'd0, 16'd0);
    rd_check("clr_ch1", 4'd1, 16'd0);
    rd_check("clr_ch2", 4'd2, 16'd0);
    start = 1'b1; step(); start = 1'b0;
    check("restart_running", 32'(running), 32'd1);

    // Start ignored while running: ch0 keeps counting from where it was.
    steps(2);
    start = 1'b1; step(); start = 1'b0;
    check("start_run_state", 32'(running), 32'd1);
    rd_check("start_run_ch0", 4'd0, 16'd3);

    // Reset mid-run with a pending read.
    clear = 1'b1; step(); clear = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    steps(3);
    rst = 1'b1; rd_req = 1'b1; rd_sel = 4'd0; step();
    rst = 1'b0; rd_req = 1'b0;
    check("mrst_rd_valid", 32'(rd_valid), 32'd0);
    check("mrst_rd_data", 32'(rd_data), 32'd0);
    check("mrst_running", 32'(running), 32'd0);
    check("mrst_halted", 32'(halted), 32'd0);
    step();
    check("mrst_no_pulse", 32'(rd_valid), 32'd0);
    rd_check("mrst_ch0", 4'd0, 16'd0);

    // 20 RUN cycles on the 4-bit instances.
    start = 1'b1; step(); start = 1'b0;
    steps(20);
    rd_req = 1'b1; rd_sel = 4'd0; step(); rd_req = 1'b0;
    check("sat_ch0", 32'(sat_rd_data), 32'd15);
    check("sat_ovf", 32'(sat_overflow), 32'b0001);
    check("wrap_ch0", 32'(wrap_rd_data), 32'd4);
    check("wrap_ovf", 32'(wrap_overflow), 32'b0001);
    check("main_ch0", 32'(rd_data), 32'd20);
    check("main_ovf", 32'(overflow), 32'd0);
    clear = 1'b1; step(); clear = 1'b0;
    check("sat_ovf_clr", 32'(sat_overflow), 32'd0);
    check("wrap_ovf_clr", 32'(wrap_overflow), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
